clk_enable_scheduler: RTL and testbench



---
 rtl/clk_enable_scheduler_pkg.sv | 17 +
 rtl/clk_enable_scheduler_ce_period_counter.sv | 41 ++++
 rtl/clk_enable_scheduler.sv | 127 ++++++++++++
 tb/tb_clk_enable_scheduler.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_enable_scheduler_pkg.sv
// Shared definitions for the clock-enable scheduler: state encodings, default sizing
// and the build switch for the double-rate buffer enable.
package clk_enable_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_PEND = 2'd1,
        ST_HOLD = 2'd2
    } ces_state_t;

    localparam int CES_DIV_W       = 4;
    localparam int CES_DEFAULT_DIV = 4;

    // Builds without the double-clocked cache read buffer tie ce_double low.
    localparam bit CACHE_READ_BUFFER_AT_DOUBLE_CLOCK = 1'b1;

endpackage

// File: rtl/clk_enable_scheduler_ce_period_counter.sv
// Period counter for the enable scheduler: counts 0..div-1 while running and flags
// the last count of a period (boundary) and the last count of its first half (half).
module ce_period_counter
    import clk_enable_scheduler_pkg::*;
#(
    parameter int DIV_W = CES_DIV_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             load_zero,
    input  logic [DIV_W-1:0] div,
    output logic             boundary,
    output logic             half
);

    localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;

    always_comb begin
        boundary = run && (cnt_q == (div - ONE));
        half     = run && (cnt_q == ((div >> 1) - ONE));
        cnt_d    = cnt_q;
        if (load_zero) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = boundary ? '0 : cnt_q + ONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/clk_enable_scheduler.sv
// Clock-enable scheduler: single-cycle core and double-rate buffer enables from one
// fabric clock, with boundary-aligned ratio changes and a parking hold.
module clk_enable_scheduler
    import clk_enable_scheduler_pkg::*;
#(
    parameter int DIV_W       = CES_DIV_W,
    parameter int DEFAULT_DIV = CES_DEFAULT_DIV
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_valid,
    input  logic [DIV_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_done,
    output logic             cfg_err,
    input  logic             hold_req,
    output logic             held,
    output logic             ce_core,
    output logic             ce_double,
    output logic [DIV_W-1:0] cur_div
);

    ces_state_t       state_q, state_d;
    logic [DIV_W-1:0] cur_div_q, cur_div_d;
    logic [DIV_W-1:0] pend_div_q, pend_div_d;
    logic             ce_core_q, ce_core_d;
    logic             ce_double_q, ce_double_d;
    logic             cfg_done_q, cfg_done_d;
    logic             cfg_err_q, cfg_err_d;

    logic boundary;
    logic half;
    logic xfer;
    logic cnt_run;
    logic cnt_zero;

    // Even and non-zero covers both limits: the largest even DIV_W-bit value is 2^DIV_W-2.
    function automatic logic div_ok(input logic [DIV_W-1:0] d);
        return (d[0] == 1'b0) && (d != '0);
    endfunction

    assign cnt_run  = (state_q != ST_HOLD);
    assign cnt_zero = (state_q == ST_HOLD);

    ce_period_counter #(
        .DIV_W (DIV_W)
    ) u_period (
        .clk       (clk),
        .reset     (reset),
        .run       (cnt_run),
        .load_zero (cnt_zero),
        .div       (cur_div_q),
        .boundary  (boundary),
        .half      (half)
    );

    assign xfer = cfg_valid && (state_q == ST_RUN);

    always_comb begin
        state_d     = state_q;
        cur_div_d   = cur_div_q;
        pend_div_d  = pend_div_q;
        cfg_done_d  = 1'b0;
        cfg_err_d   = 1'b0;
        ce_core_d   = boundary;
        ce_double_d = CACHE_READ_BUFFER_AT_DOUBLE_CLOCK && (boundary || half);

        unique case (state_q)
            ST_RUN: begin
                cfg_err_d = xfer && !div_ok(cfg_div);
                // An accepted ratio wins over a same-edge hold; the hold is taken at the
                // following boundary, after the new ratio is in force.
                if (xfer && div_ok(cfg_div)) begin
                    pend_div_d = cfg_div;
                    state_d    = ST_PEND;
                end else if (boundary && hold_req) begin
                    state_d = ST_HOLD;
                end
            end
            ST_PEND: begin
                if (boundary) begin
                    cur_div_d  = pend_div_q;
                    cfg_done_d = 1'b1;
                    state_d    = hold_req ? ST_HOLD : ST_RUN;
                end
            end
            ST_HOLD: begin
                if (!hold_req) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_RUN;
            cur_div_q   <= DIV_W'(DEFAULT_DIV);
            ce_core_q   <= 1'b0;
            ce_double_q <= 1'b0;
            cfg_done_q  <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_div_q   <= cur_div_d;
            ce_core_q   <= ce_core_d;
            ce_double_q <= ce_double_d;
            cfg_done_q  <= cfg_done_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    // The pending ratio is only read in PEND, which reset never leaves us in.
    always_ff @(posedge clk) begin
        pend_div_q <= pend_div_d;
    end

    assign cfg_ready = (state_q == ST_RUN);
    assign held      = (state_q == ST_HOLD);
    assign ce_core   = ce_core_q;
    assign ce_double = ce_double_q;
    assign cfg_done  = cfg_done_q;
    assign cfg_err   = cfg_err_q;
    assign cur_div   = cur_div_q;

endmodule

// File: tb/tb_clk_enable_scheduler.sv
// Scoreboard bench for clk_enable_scheduler: expected pulse events are queued per
// scenario and a negedge monitor pops and compares them as the DUT emits pulses.
module tb_clk_enable_scheduler;
    import clk_enable_scheduler_pkg::*;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         cfg_valid = 1'b0;
    logic [W-1:0] cfg_div = '0;
    logic         hold_req = 1'b0;
    logic         cfg_ready, cfg_done, cfg_err, held, ce_core, ce_double;
    logic [W-1:0] cur_div;

    int edge_n;
    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        int e;
        bit core;
        bit dbl;
        bit done;
        bit err;
        int cd;
        bit hld;
    } ev_t;

    ev_t exp_q[$];

    clk_enable_scheduler #(
        .DIV_W       (W),
        .DEFAULT_DIV (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cfg_valid (cfg_valid),
        .cfg_div   (cfg_div),
        .cfg_ready (cfg_ready),
        .cfg_done  (cfg_done),
        .cfg_err   (cfg_err),
        .hold_req  (hold_req),
        .held      (held),
        .ce_core   (ce_core),
        .ce_double (ce_double),
        .cur_div   (cur_div)
    );

    always #5 clk = ~clk;

    // Edge 1 is the first rising edge with reset low.
    always @(posedge clk or posedge reset) begin
        if (reset) edge_n <= 0;
        else       edge_n <= edge_n + 1;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int e, input bit c, input bit d, input bit dn,
                        input bit er, input int cd, input bit h);
        ev_t ev;
        ev.e = e; ev.core = c; ev.dbl = d; ev.done = dn; ev.err = er; ev.cd = cd; ev.hld = h;
        exp_q.push_back(ev);
    endtask

    task automatic push_d4(input int first, input int last);
        for (int e = first; e <= last; e += 2) push(e, (e % 4) == 0, 1'b1, 1'b0, 1'b0, 4, 1'b0);
    endtask

    task automatic wait_edge(input int n);
        int guard = 0;
        while (edge_n != n && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        if (edge_n != n) chk("wait_edge_timeout", edge_n, n);
    endtask

    task automatic assert_reset();
        @(negedge clk);
        #2;
        reset     = 1'b1;
        cfg_valid = 1'b0;
        hold_req  = 1'b0;
    endtask

    task automatic release_reset();
        @(negedge clk);
        #2;
        reset = 1'b0;
    endtask

    task automatic offer_at(input int e, input int d);
        wait_edge(e - 1);
        cfg_div   = W'(d);
        cfg_valid = 1'b1;
        wait_edge(e);
        cfg_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        #1;
        chk(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    always @(negedge clk) begin
        if (reset === 1'b0 && (ce_core || ce_double || cfg_done || cfg_err)) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_event: got pulse at edge %0d (core=%0d dbl=%0d done=%0d err=%0d) expected none",
                         edge_n, ce_core, ce_double, cfg_done, cfg_err);
            end else begin
                ev_t ev;
                ev = exp_q.pop_front();
                if (edge_n != ev.e || ce_core != ev.core || ce_double != ev.dbl ||
                    cfg_done != ev.done || cfg_err != ev.err || int'(cur_div) != ev.cd ||
                    held != ev.hld) begin
                    n_fail++;
                    $display("FAIL event: got edge=%0d core=%0d dbl=%0d done=%0d err=%0d cur=%0d held=%0d expected edge=%0d core=%0d dbl=%0d done=%0d err=%0d cur=%0d held=%0d",
                             edge_n, ce_core, ce_double, cfg_done, cfg_err, cur_div, held,
                             ev.e, ev.core, ev.dbl, ev.done, ev.err, ev.cd, ev.hld);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got still running expected finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0;
        #1 reset = 1'b1;
        #7;
        chk("reset_cur_div", cur_div, 4);
        chk("reset_cfg_ready", cfg_ready, 1);
        chk("reset_held", held, 0);
        chk("reset_pulses", {ce_core, ce_double, cfg_done, cfg_err}, 0);
        release_reset();

        // D=4 free-running cadence
        push_d4(2, 20);
        wait_edge(20);
        drain("drain_cadence");

        // Ratio change to 6 accepted at edge 5
        assert_reset();
        release_reset();
        push_d4(2, 6);
        push(8, 1, 1, 1, 0, 6, 0);
        push(11, 0, 1, 0, 0, 6, 0);
        push(14, 1, 1, 0, 0, 6, 0);
        push(17, 0, 1, 0, 0, 6, 0);
        push(20, 1, 1, 0, 0, 6, 0);
        offer_at(5, 6);
        chk("pend_cfg_ready", cfg_ready, 0);
        wait_edge(8);
        chk("after_load_cfg_ready", cfg_ready, 1);
        wait_edge(20);
        drain("drain_ratio6");

        // Rejected ratios: odd, zero, odd above the limit
        assert_reset();
        release_reset();
        push(2, 0, 1, 0, 0, 4, 0);
        push(3, 0, 0, 0, 1, 4, 0);
        push(4, 1, 1, 0, 0, 4, 0);
        push(6, 0, 1, 0, 0, 4, 0);
        push(7, 0, 0, 0, 1, 4, 0);
        push(8, 1, 1, 0, 0, 4, 0);
        push(10, 0, 1, 0, 1, 4, 0);
        push(12, 1, 1, 0, 0, 4, 0);
        offer_at(3, 5);
        chk("err_ready_5", cfg_ready, 1);
        offer_at(7, 0);
        chk("err_ready_0", cfg_ready, 1);
        offer_at(10, 15);
        wait_edge(12);
        chk("err_cur_div", cur_div, 4);
        drain("drain_errors");

        // Hold raised at edge 5, dropped at edge 20
        assert_reset();
        release_reset();
        push_d4(2, 6);
        push(8, 1, 1, 0, 0, 4, 1);
        push(22, 0, 1, 0, 0, 4, 0);
        push(24, 1, 1, 0, 0, 4, 0);
        wait_edge(4);
        hold_req = 1'b1;
        wait_edge(15);
        chk("hold_held", held, 1);
        chk("hold_cfg_ready", cfg_ready, 0);
        wait_edge(19);
        hold_req = 1'b0;
        wait_edge(20);
        chk("release_held", held, 0);
        wait_edge(24);
        drain("drain_hold");

        // Pending ratio 8 and hold meeting at the same boundary
        assert_reset();
        release_reset();
        push(2, 0, 1, 0, 0, 4, 0);
        push(4, 1, 1, 1, 0, 8, 1);
        push(14, 0, 1, 0, 0, 8, 0);
        push(18, 1, 1, 0, 0, 8, 0);
        push(22, 0, 1, 0, 0, 8, 0);
        push(26, 1, 1, 0, 0, 8, 0);
        offer_at(2, 8);
        hold_req = 1'b1;
        wait_edge(9);
        hold_req = 1'b0;
        wait_edge(10);
        chk("pend_hold_release_held", held, 0);
        wait_edge(26);
        drain("drain_pend_hold");

        // Reset in the middle of a pending change
        assert_reset();
        release_reset();
        push_d4(2, 6);
        offer_at(5, 6);
        wait_edge(6);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_ce_double", ce_double, 0);
        chk("async_rst_cfg_ready", cfg_ready, 1);
        chk("async_rst_cur_div", cur_div, 4);
        chk("async_rst_done", cfg_done, 0);
        drain("drain_pre_reset");
        release_reset();
        push_d4(2, 8);
        wait_edge(8);
        drain("drain_post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
